// File: rtl/check_sequencer.sv
// check_sequencer: FIFO-fed instruction issuer with OpDone/timeout scoring.
// Define CHECK_SEQ_SCORE_EN to build the pass/fail counters; otherwise they read 0.
module check_sequencer #(
    parameter int DEPTH    = 8,
    parameter int WAIT_CYC = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    output logic        in_ready,
    output logic [31:0] inst,
    output logic        pcEn,
    input  logic        OpDone,
    output logic        busy,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic [15:0] issue_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
    state_t      state, state_nxt;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic [31:0] held;
    logic [7:0]  wcnt;
    logic        empty, full, push, pop, done, timeout;
    assign empty    = wptr == rptr;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign busy     = (state != IDLE) || !empty;
    always_comb begin
        state_nxt = state;
        pcEn      = 1'b0;
        inst      = '0;
        pop       = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE:  state_nxt = empty ? IDLE : ISSUE;
            ISSUE: begin
                pcEn      = 1'b1;
                inst      = mem[rptr[AW-1:0]];
                pop       = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                pcEn      = 1'b1;
                inst      = held;
                done      = OpDone;
                timeout   = !OpDone && (wcnt == 8'(WAIT_CYC - 1));
                state_nxt = (done || timeout) ? GAP : WAIT;
            end
            GAP:   state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    // Storage is unreset; reset only clears the pointers, so a coincident push is lost.
    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= in_inst;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            held      <= '0;
            wcnt      <= '0;
            issue_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr      <= rptr + 1'b1;
                held      <= inst;
                wcnt      <= '0;
                issue_cnt <= issue_cnt + {15'd0, issue_cnt != 16'hFFFF};
            end else if (state == WAIT) begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end
`ifdef CHECK_SEQ_SCORE_EN
    logic [15:0] pass_q, fail_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q <= '0;
            fail_q <= '0;
        end else begin
            if (done) pass_q <= pass_q + {15'd0, pass_q != 16'hFFFF};
            if (timeout) fail_q <= fail_q + {15'd0, fail_q != 16'hFFFF};
        end
    end
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif
endmodule

// File: tb/tb_check_sequencer.sv
// tb_check_sequencer: directed vectors for check_sequencer at default parameters.
module tb_check_sequencer;
    logic        clk = 1'b0;
    logic        reset, in_valid, OpDone;
    logic [31:0] in_inst;
    logic        in_ready, pcEn, busy;
    logic [31:0] inst;
    logic [15:0] pass_cnt, fail_cnt, issue_cnt;
    int          checks = 0;
    int          failures = 0;
    int          n_rise, n;
    logic        prev_pc = 1'b0;
    logic [31:0] first_w, last_w;
    int          exp_issue = 0;
    int          exp_pass = 0;
    int          exp_fail = 0;
`ifdef CHECK_SEQ_SCORE_EN
    localparam bit SCORE = 1'b1;
`else
    localparam bit SCORE = 1'b0;
`endif
    check_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .inst(inst), .pcEn(pcEn), .OpDone(OpDone),
        .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .issue_cnt(issue_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] sc(input int v);
        return SCORE ? 32'(v) : 32'd0;
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Advance one clock and sample 1ns after the edge; track pcEn rising edges.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pcEn && !prev_pc) begin
            n_rise++;
            if (n_rise == 1) first_w = inst;
            last_w = inst;
        end
        prev_pc = pcEn;
    endtask
    task automatic counters(input string tag);
        check({tag, "_pass"}, 32'(pass_cnt), sc(exp_pass));
        check({tag, "_fail"}, 32'(fail_cnt), sc(exp_fail));
        check({tag, "_issue"}, 32'(issue_cnt), 32'(exp_issue));
    endtask
    initial begin
        reset = 1'b1; in_valid = 1'b1; in_inst = 32'hDEADBEEF; OpDone = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_pcen", 32'(pcEn), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        counters("rst");
        reset = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_push_dropped", 32'(busy), 32'd0);
        // single instruction, OpDone in 3rd WAIT cycle
        in_inst = 32'h00221820; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_idle_pcen", 32'(pcEn), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        check("issue_pcen", 32'(pcEn), 32'd1);
        check("issue_inst", inst, 32'h00221820);
        check("issue_cnt_pre", 32'(issue_cnt), 32'd0);
        tick();
        exp_issue = 1;
        check("wait_inst_held", inst, 32'h00221820);
        check("wait_issue_cnt", 32'(issue_cnt), 32'd1);
        tick();
        tick();
        OpDone = 1'b1;
        check("wait3_pcen", 32'(pcEn), 32'd1);
        tick();
        OpDone = 1'b0;
        exp_pass = 1;
        check("gap_pcen", 32'(pcEn), 32'd0);
        check("gap_inst", inst, 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        counters("single");
        tick();
        check("idle_after_gap_busy", 32'(busy), 32'd0);
        OpDone = 1'b1;
        tick();
        OpDone = 1'b0;
        counters("opdone_idle");
        // timeout: pcEn high for ISSUE plus WAIT_CYC cycles
        in_inst = 32'h8C430004; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        repeat (20) begin
            tick();
            if (pcEn) n++;
        end
        exp_issue = 2; exp_fail = 1;
        check("timeout_pcen_len", 32'(n), 32'd6);
        counters("timeout");
        // OpDone on the timeout cycle counts as a pass only
        in_inst = 32'hAC650008; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("edge_last_wait_pcen", 32'(pcEn), 32'd1);
        OpDone = 1'b1;
        tick();
        OpDone = 1'b0;
        exp_issue = 3; exp_pass = 2;
        check("edge_gap_pcen", 32'(pcEn), 32'd0);
        counters("edge");
        tick();
        tick();
        // full FIFO while the core stalls on the first instruction
        in_inst = 32'h11111111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_rise = 0;
        for (int i = 0; i < 9; i++) begin
            in_inst = 32'h10000000 + 32'(i);
            in_valid = 1'b1;
            check($sformatf("full_ready%0d", i), 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("full_ready_after_pop", 32'(in_ready), 32'd1);
        repeat (100) tick();
        exp_issue = 12; exp_fail = 10;
        check("full_issued", 32'(n_rise), 32'd8);
        check("full_first", first_w, 32'h10000000);
        check("full_last", last_w, 32'h10000007);
        check("full_drained_busy", 32'(busy), 32'd0);
        counters("full");
        // reset mid-WAIT with three entries queued
        for (int i = 0; i < 4; i++) begin
            in_inst = 32'h20000000 + 32'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("midwait_pcen", 32'(pcEn), 32'd1);
        reset = 1'b1;
        tick();
        exp_issue = 0; exp_pass = 0; exp_fail = 0;
        check("midrst_pcen", 32'(pcEn), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        counters("midrst");
        reset = 1'b0;
        n_rise = 0;
        repeat (20) tick();
        check("midrst_no_issue", 32'(n_rise), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        counters("midrst_after");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
